rv_fifo: RTL and testbench
==========================

RV_FIFO -- requirements
Module: rv_fifo

Interface
REQ-001 Parameter DW, default 32, data width in bits.
REQ-002 Parameter DEPTH, default 4, number of entries; power of two, at least 1.
REQ-003 Parameter FWFT, default 0; 0 = registered output, 1 = first-word fall-through bypass when empty.
REQ-004 Parameter AF_THRESH, default DEPTH-1, occupancy at or above which almost_full asserts.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 clr  input  1  synchronous flush.
REQ-008 in_valid  input  1  producer has data.
REQ-009 in_ready  output  1  FIFO accepts data.
REQ-010 in_data  input  DW  write data.
REQ-011 out_valid  output  1  head entry available.
REQ-012 out_ready  input  1  consumer accepts head.
REQ-013 out_data  output  DW  head data.
REQ-014 count  output  $clog2(DEPTH+1)  current occupancy.
REQ-015 almost_full  output  1  count >= AF_THRESH.

Function
REQ-016 push = in_valid & in_ready; pop = out_valid & out_ready; evaluated each cycle.
REQ-017 in_ready SHALL equal (count != DEPTH); no combinational path from out_ready to in_ready.
REQ-018 FWFT=0: out_valid = (count != 0); out_data = entry at read pointer; push in cycle N visible at output in cycle N+1.
REQ-019 FWFT=1: when count==0, out_valid = in_valid and out_data = in_data (zero latency); push and pop in the same cycle leave count at 0 with no write to storage.
REQ-020 Write and read pointers SHALL be max(1,$clog2(DEPTH)) bits, advancing on push/pop, wrapping DEPTH-1 -> 0.
REQ-021 Count SHALL increment on push-only, decrement on pop-only, hold on both or neither.
REQ-022 When full, a simultaneous pop SHALL NOT enable a push in that cycle.
REQ-023 Pop with count==0 (FWFT=0) SHALL be impossible, since out_valid is 0; no underflow.
REQ-024 clr SHALL take priority over push and pop: pointers and count go to 0 next cycle, the push in the clr cycle is discarded, and storage contents are not cleared.
REQ-025 almost_full SHALL be combinational from count.
REQ-026 Data ordering SHALL be strictly first-in-first-out; no entry is dropped or duplicated.

Reset
REQ-027 Asserting rst (low) SHALL clear pointers and count to 0 immediately, independent of clk.
REQ-028 While rst is low: in_ready=0, out_valid=0, count=0, almost_full=0 (unless AF_THRESH=0); out_data is unspecified.
REQ-029 Storage array SHALL NOT be reset.
REQ-030 On the first clk edge after rst deasserts, in_ready SHALL be 1 and push is accepted.
REQ-031 rst asserted mid-transfer SHALL discard all contents; no entry is presented after reset.

Structure
REQ-032 is_pow2 SHALL remain in the shared defines; an elaboration check SHALL $error when DEPTH fails is_pow2 or AF_THRESH > DEPTH.
REQ-033 No new enums or typedefs are required; the count width expression SHALL be a localparam.
REQ-034 Storage SHALL be one sub-module rv_fifo_ram (DEPTH x DW, one synchronous write port, one asynchronous read port); pointer and count control stays in rv_fifo.
REQ-035 The top-level ports SHALL be connectable to rv_if RX and TX modports without glue logic.

Verification (DW=32, DEPTH=4, AF_THRESH=3 unless stated)
REQ-036 Push 0x11,0x22,0x33,0x44 with out_ready=0 -> count 1,2,3,4; almost_full at count 3; in_ready=0 at 4; a fifth push of 0x55 is ignored.
REQ-037 From full, out_ready=1 for 4 cycles -> out_data 0x11,0x22,0x33,0x44 in order; then out_valid=0 and count=0.
REQ-038 Continuous push/pop over 10 words 0x0..0x9 at count=2 -> count stays 2, order preserved across pointer wrap.
REQ-039 FWFT=1, empty, in_valid=1, in_data=0xAB, out_ready=1 -> out_valid=1 and out_data=0xAB in the same cycle; count stays 0.
REQ-040 Count=3, assert clr with push of 0x99 -> next cycle count=0, out_valid=0; 0x99 never appears.
REQ-041 Count=2, rst low between clock edges -> count=0, out_valid=0, in_ready=0 immediately; after release the first push 0x77 is the first word out.

Source files
------------

// File: rtl/rv_fifo_pkg.sv
// Shared definitions for the rv_fifo block: parameter sanity helpers.
package rv_fifo_pkg;

  // True when n is a positive power of two (1, 2, 4, ...).
  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  // Pointer width for a DEPTH-entry store; never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rv_if.sv
// Valid/ready stream bundle. A TX modport drives a FIFO's in_* side and an
// RX modport receives from its out_* side; the signal set maps one-to-one.
interface rv_if #(
  parameter int DW = 32
);
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  modport TX (output valid, output data, input ready);
  modport RX (input valid, input data, output ready);
endinterface

// File: rtl/rv_fifo_ram.sv
// DEPTH x DW storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the controller.
module rv_fifo_ram
  import rv_fifo_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write the addressed entry on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read is combinational so the head entry is visible without a cycle delay.
  always_comb begin
    rdata = mem[raddr];
  end

endmodule

// File: rtl/rv_fifo.sv
// Valid/ready FIFO with optional first-word fall-through bypass.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready depends only on the occupancy (and reset), never on
// out_ready, so no combinational path exists from the consumer to the
// producer. A consumer may not assume out_valid stays high unless it pops.
module rv_fifo
  import rv_fifo_pkg::*;
#(
  parameter  int DW        = 32,
  parameter  int DEPTH     = 4,
  parameter  int FWFT      = 0,
  parameter  int AF_THRESH = DEPTH - 1,
  localparam int CW        = $clog2(DEPTH + 1),
  localparam int AW        = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] count,
  output logic          almost_full
);

  // Reject illegal configurations at elaboration.
  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("rv_fifo: DEPTH (%0d) must be a power of two", DEPTH);
  end
  if (AF_THRESH > DEPTH) begin : g_bad_thresh
    $error("rv_fifo: AF_THRESH (%0d) exceeds DEPTH (%0d)", AF_THRESH, DEPTH);
  end

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [DW-1:0] ram_rdata;

  logic empty;
  logic full;
  logic bypass;
  logic push;
  logic pop;
  logic thru;
  logic wr_en;
  logic rd_adv;

  // Occupancy flags and the bypass window (FWFT only, while empty).
  always_comb begin
    empty  = (cnt == '0);
    full   = (cnt == CW'(DEPTH));
    bypass = (FWFT != 0) && empty;
  end

  // Handshake outputs; rst gates them so nothing is offered or accepted
  // while reset is held, and releases them the instant reset goes high.
  always_comb begin
    in_ready  = rst & ~full;
    out_valid = rst & (bypass ? in_valid : ~empty);
    out_data  = bypass ? in_data : ram_rdata;
  end

  // Transfer decode. A word that passes straight through in bypass is never
  // written to storage, and a flush suppresses the write in its own cycle.
  always_comb begin
    push   = in_valid & in_ready;
    pop    = out_valid & out_ready;
    thru   = bypass & push & pop;
    wr_en  = push & ~thru & ~clr;
    rd_adv = pop & ~thru;
  end

  // Write pointer advances on every stored word, wrapping DEPTH-1 -> 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
    end else if (wr_en) begin
      wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
    end
  end

  // Read pointer advances on every word popped from storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
    end else if (rd_adv) begin
      rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
    end
  end

  // Occupancy: up on store-only, down on pop-only, hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else begin
      case ({wr_en, rd_adv})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Status outputs derived directly from the occupancy register.
  always_comb begin
    count       = cnt;
    almost_full = (cnt >= CW'(AF_THRESH));
  end

  rv_fifo_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_rv_fifo.sv
// Bench for rv_fifo: a registered-output instance driven through a
// scoreboard model, plus a fall-through instance exercised directly.
module tb_rv_fifo;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Registered-output instance (FWFT=0)
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  count;
  logic        almost_full;

  // Fall-through instance (FWFT=1)
  logic        f_clr = 1'b0;
  logic        f_in_valid = 1'b0;
  logic        f_in_ready;
  logic [31:0] f_in_data = '0;
  logic        f_out_valid;
  logic        f_out_ready = 1'b0;
  logic [31:0] f_out_data;
  logic [2:0]  f_count;
  logic        f_almost_full;

  rv_fifo #(.DW(32), .DEPTH(4), .FWFT(0), .AF_THRESH(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .count       (count),
    .almost_full (almost_full)
  );

  rv_fifo #(.DW(32), .DEPTH(4), .FWFT(1), .AF_THRESH(3)) dut_f (
    .clk         (clk),
    .rst         (rst),
    .clr         (f_clr),
    .in_valid    (f_in_valid),
    .in_ready    (f_in_ready),
    .in_data     (f_in_data),
    .out_valid   (f_out_valid),
    .out_ready   (f_out_ready),
    .out_data    (f_out_data),
    .count       (f_count),
    .almost_full (f_almost_full)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int m_cnt = 0;
  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge: drive inputs, check outputs on the
  // falling edge against the model, update the model, move to next cycle.
  task automatic cycle(input logic iv, input logic [31:0] id,
                       input logic ordy, input logic cl);
    logic push_e;
    logic pop_e;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    clr       = cl;
    @(negedge clk);
    chk("in_ready", {31'b0, in_ready}, {31'b0, m_cnt != 4});
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_cnt != 0});
    if (m_cnt != 0) chk("out_data", out_data, exp_q[0]);
    chk("count", {29'b0, count}, m_cnt);
    chk("almost_full", {31'b0, almost_full}, {31'b0, m_cnt >= 3});
    push_e = iv && (m_cnt != 4);
    pop_e  = ordy && (m_cnt != 0);
    if (cl) begin
      exp_q.delete();
    end else begin
      if (pop_e) void'(exp_q.pop_front());
      if (push_e) exp_q.push_back(id);
    end
    m_cnt = exp_q.size();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset held low: outputs quiet even with a producer offering data.
    f_in_valid = 1'b1;
    f_in_data  = 32'hDEAD;
    #12;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_count", {29'b0, count}, 32'd0);
    chk("rst_almost_full", {31'b0, almost_full}, 32'd0);
    chk("rst_f_out_valid", {31'b0, f_out_valid}, 32'd0);
    chk("rst_f_in_ready", {31'b0, f_in_ready}, 32'd0);
    f_in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Fill to full, fifth push ignored.
    cycle(1'b1, 32'h11, 1'b0, 1'b0);
    cycle(1'b1, 32'h22, 1'b0, 1'b0);
    cycle(1'b1, 32'h33, 1'b0, 1'b0);
    cycle(1'b1, 32'h44, 1'b0, 1'b0);
    cycle(1'b1, 32'h55, 1'b0, 1'b0);
    chk("full_count", {29'b0, count}, 32'd4);
    // Drain in order, then observe empty.
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Streaming at occupancy 2 across pointer wrap.
    cycle(1'b1, 32'h100, 1'b0, 1'b0);
    cycle(1'b1, 32'h101, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, i, 1'b1, 1'b0);
    chk("stream_count", {29'b0, count}, 32'd2);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush with a concurrent push at occupancy 3.
    cycle(1'b1, 32'hC1, 1'b0, 1'b0);
    cycle(1'b1, 32'hC2, 1'b0, 1'b0);
    cycle(1'b1, 32'hC3, 1'b0, 1'b0);
    cycle(1'b1, 32'h99, 1'b0, 1'b1);
    chk("clr_count", {29'b0, count}, 32'd0);
    chk("clr_out_valid", {31'b0, out_valid}, 32'd0);
    cycle(1'b1, 32'hA1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle at occupancy 2.
    cycle(1'b1, 32'hE1, 1'b0, 1'b0);
    cycle(1'b1, 32'hE2, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_count", {29'b0, count}, 32'd0);
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'b0, in_ready}, 32'd0);
    exp_q.delete();
    m_cnt = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle(1'b1, 32'h77, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 60; i++)
      cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Fall-through instance: zero-latency bypass while empty.
    f_in_valid  = 1'b1;
    f_in_data   = 32'hAB;
    f_out_ready = 1'b1;
    #1;
    chk("fwft_valid", {31'b0, f_out_valid}, 32'd1);
    chk("fwft_data", f_out_data, 32'hAB);
    chk("fwft_count", {29'b0, f_count}, 32'd0);
    @(posedge clk);
    #1;
    chk("fwft_count_after", {29'b0, f_count}, 32'd0);
    // Bypassed word not taken: it is stored.
    f_in_data   = 32'hCD;
    f_out_ready = 1'b0;
    #1;
    chk("fwft_hold_data", f_out_data, 32'hCD);
    @(posedge clk);
    #1;
    chk("fwft_stored_count", {29'b0, f_count}, 32'd1);
    chk("fwft_stored_data", f_out_data, 32'hCD);
    // Simultaneous push and pop from storage.
    f_in_data   = 32'hEF;
    f_out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("fwft_pp_count", {29'b0, f_count}, 32'd1);
    chk("fwft_pp_data", f_out_data, 32'hEF);
    f_in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("fwft_empty_count", {29'b0, f_count}, 32'd0);
    chk("fwft_empty_valid", {31'b0, f_out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
